conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/viterbi_pkg.sv | 7 +
 rtl/conv_enc_core.sv | 13 +
 rtl/conv_encoder.sv | 102 ++++++++++
 tb/tb_conv_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and types for the convolutional encoder/decoder pair.
package viterbi_pkg;
    localparam int K = 4;
    localparam logic [K-1:0] G0_DEF = 4'b1111;
    localparam logic [K-1:0] G1_DEF = 4'b1101;
    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} enc_state_t;
endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational parity pair {p1,p0} for input bit u and shift register s.
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic         u,
    input  logic [K-2:0] s,
    output logic [1:0]   p
);
    assign p = {^({u, s} & G0), ^({u, s} & G1)};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: framed rate-1/2 K=4 convolutional encoder with zero tail and a one-deep output register.
module conv_encoder
    import viterbi_pkg::*;
#(
    parameter int FRAME_W = 10,
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               d_in,
    input  logic               d_in_valid,
    output logic               d_in_ready,
    output logic [1:0]         d_out,
    output logic               d_out_valid,
    input  logic               d_out_ready,
    output logic               busy,
    output logic               done
);
    enc_state_t state, state_nx;
    logic [K-2:0] s, s_nx;
    logic [FRAME_W-1:0] len, len_nx, cnt, cnt_nx;
    logic [1:0] tail, tail_nx, sym, d_out_nx;
    logic dv_nx, slot_free, load_data, load_tail, u;

    conv_enc_core #(.G0(G0), .G1(G1)) core (.u(u), .s(s), .p(sym));

    always_comb begin
        slot_free  = !d_out_valid || d_out_ready;
        d_in_ready = enable && state == DATA && slot_free;
        load_data  = d_in_valid && d_in_ready;
        load_tail  = enable && state == TAIL && slot_free;
        u          = load_data && d_in;
        done       = enable && state == DRAIN && d_out_valid && d_out_ready;
        busy       = state != IDLE;
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        len_nx   = len;
        cnt_nx   = cnt;
        tail_nx  = tail;
        d_out_nx = d_out;
        dv_nx    = d_out_valid && !d_out_ready;
        if (load_data || load_tail) begin
            s_nx     = {u, s[K-2:1]};
            d_out_nx = sym;
            dv_nx    = 1'b1;
        end
        case (state)
            IDLE: if (start && frame_len != '0) begin
                state_nx = DATA;
                len_nx   = frame_len;
                s_nx     = '0;
                cnt_nx   = '0;
                tail_nx  = '0;
            end
            DATA: if (load_data) begin
                cnt_nx = cnt + 1'b1;
                if (cnt == len - 1'b1) state_nx = TAIL;
            end
            TAIL: if (load_tail) begin
                tail_nx = tail + 1'b1;
                if (tail == 2'(K - 2)) state_nx = DRAIN;
            end
            DRAIN: if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // enable low overrides every handshake above
        if (!enable) begin
            state_nx = IDLE;
            s_nx     = '0;
            cnt_nx   = '0;
            tail_nx  = '0;
            dv_nx    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s           <= '0;
            len         <= '0;
            cnt         <= '0;
            tail        <= '0;
            d_out       <= '0;
            d_out_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            len         <= len_nx;
            cnt         <= cnt_nx;
            tail        <= tail_nx;
            d_out       <= d_out_nx;
            d_out_valid <= dv_nx;
        end
    end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: randomized frames against a tap-delay reference model, checked by a scoreboard monitor.
module tb_conv_encoder;
    localparam int FW = 10;
    localparam logic [3:0] G0 = 4'b1111;
    localparam logic [3:0] G1 = 4'b1101;

    logic clk = 0, rst = 0, enable = 1, start = 0, d_in = 0, d_in_valid = 0, d_out_ready = 1;
    logic d_in_ready, d_out_valid, busy, done;
    logic [FW-1:0] frame_len = '0;
    logic [1:0] d_out;
    int checks = 0, passes = 0, cyc = 0, stall_until = 0;
    bit rmode = 0;
    logic [2:0] sb[$];
    logic hold_p = 0, done_p = 0;
    logic [1:0] hold_v = '0;

    conv_encoder #(.FRAME_W(FW), .G0(G0), .G1(G1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .frame_len(frame_len),
        .d_in(d_in), .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .d_out(d_out), .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        #2;
        d_out_ready = (cyc < stall_until) ? 1'b0 : (rmode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Each symbol n is the tap-weighted parity of input bits x[n]..x[n-3]; bits outside the frame are 0.
    function automatic void push_model(input int len, input logic [63:0] fb);
        for (int n = 0; n < len + 3; n++) begin
            logic p1, p0, x;
            p1 = 0;
            p0 = 0;
            for (int k = 0; k < 4; k++) begin
                x = (n - k >= 0 && n - k < len) ? fb[n-k] : 1'b0;
                p1 ^= G0[3-k] & x;
                p0 ^= G1[3-k] & x;
            end
            sb.push_back({n == len + 2, p1, p0});
        end
    endfunction

    always @(negedge clk) begin : mon
        logic [2:0] e;
        if (rst && enable && d_out_valid && !d_out_ready) chk("ready_blocked", int'(d_in_ready), 0);
        if (hold_p && rst) chk("hold_stable", int'({d_out_valid, d_out}), int'({1'b1, hold_v}));
        hold_p = rst && enable && d_out_valid && !d_out_ready;
        hold_v = d_out;
        if (done_p && rst) chk("busy_after_done", int'(busy), 0);
        done_p = done;
        if (rst && enable && d_out_valid && d_out_ready) begin
            if (sb.size() == 0) chk("extra_symbol", int'(d_out), -1);
            else begin
                e = sb.pop_front();
                chk("symbol", int'(d_out), int'(e[1:0]));
                chk("done_flag", int'(done), int'(e[2]));
            end
        end else if (done) chk("spurious_done", 1, 0);
    end

    task automatic begin_frame(input int len, input logic [63:0] fb, input bit model);
        if (model) push_model(len, fb);
        start = 1;
        frame_len = FW'(len);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic feed(input int n, input logic [63:0] fb, input int start_at, input int stall_at);
        int idx = 0, b = 0;
        bit stalled = 0;
        logic acc;
        while (idx < n && b < 2000) begin
            d_in = fb[idx];
            d_in_valid = (idx == stall_at) || ($urandom_range(0, 3) != 0);
            if (idx == stall_at && !stalled) begin
                stall_until = cyc + 5;
                stalled = 1;
            end
            if (idx == start_at) begin
                start = 1;
                frame_len = FW'(n + 7);
            end
            @(negedge clk);
            acc = d_in_valid && d_in_ready;
            @(posedge clk); #1;
            start = 0;
            if (acc) idx++;
            b++;
        end
        chk("feed_budget", int'(idx >= n), 1);
        d_in_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int b = 0;
        while (busy && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk({nm, "_idle"}, int'(busy), 0);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_d_out"}, int'(d_out), 0);
        chk({nm, "_d_out_valid"}, int'(d_out_valid), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_d_in_ready"}, int'(d_in_ready), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fb;
        int len;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1;
        @(posedge clk); #1;

        sb.push_back(3'b011); sb.push_back(3'b011); sb.push_back(3'b010); sb.push_back(3'b111);
        begin_frame(1, 64'h1, 0);
        feed(1, 64'h1, -1, -1);
        wait_idle("single_one");

        begin_frame(8, 64'h0, 1);
        feed(8, 64'h0, -1, -1);
        wait_idle("zeros");

        rmode = 1;
        fb = {$urandom, $urandom};
        begin_frame(12, fb, 1);
        feed(12, fb, 3, 6);
        wait_idle("stall_restart");

        fb = {$urandom, $urandom};
        begin_frame(6, fb, 1);
        feed(6, fb, -1, -1);
        stall_until = cyc + 1000;
        @(posedge clk); #1;
        enable = 0;
        @(posedge clk); #1;
        chk("en_low_valid", int'(d_out_valid), 0);
        chk("en_low_busy", int'(busy), 0);
        chk("en_low_done", int'(done), 0);
        enable = 1;
        sb.delete();
        stall_until = 0;
        fb = {$urandom, $urandom};
        begin_frame(9, fb, 1);
        feed(9, fb, -1, -1);
        wait_idle("after_enable");

        fb = {$urandom, $urandom};
        begin_frame(10, fb, 1);
        feed(4, fb, -1, -1);
        rst = 0;
        #1;
        chk_reset_outputs("mid_rst");
        sb.delete();
        @(posedge clk); #1;
        rst = 1;
        begin_frame(0, 64'h0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_len_busy", int'(busy), 0);
            chk("zero_len_ready", int'(d_in_ready), 0);
        end

        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 30);
            fb = {$urandom, $urandom};
            begin_frame(len, fb, 1);
            feed(len, fb, -1, -1);
            wait_idle("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
